// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: request and FIFO-write bundle shared by the requesters and the arbiter
//   master : enable, req_valid, req_last, req_data, fifo_rd_en driven by the requester/consumer side
//   slave  : req_ready, fifo_wr_en, fifo_data_in, grant_id, busy, occupancy, err_underflow driven by the arbiter
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int OW = $clog2(DEPTH) + 1;
    logic                     enable;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_last;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic                     fifo_rd_en;
    logic [NUM_REQ-1:0]       req_ready;
    logic                     fifo_wr_en;
    logic [WIDTH-1:0]         fifo_data_in;
    logic [IW-1:0]            grant_id;
    logic                     busy;
    logic [OW-1:0]            occupancy;
    logic                     err_underflow;
    modport master (
        output enable, req_valid, req_last, req_data, fifo_rd_en,
        input  req_ready, fifo_wr_en, fifo_data_in, grant_id, busy, occupancy, err_underflow
    );
    modport slave (
        input  enable, req_valid, req_last, req_data, fifo_rd_en,
        output req_ready, fifo_wr_en, fifo_data_in, grant_id, busy, occupancy, err_underflow
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among NUM_REQ requesters
//   clk, rst : single rising-edge clock, synchronous active-high reset
//   bus      : fifo_wr_arbiter_if.slave carrying the request, FIFO write and status signals
//   ARB_BURST_LOCK_EN : when defined, a grant is held until a beat with req_last is accepted;
//                       otherwise every accepted beat releases the grant
module fifo_wr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.slave  bus
);
    localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int OW = $clog2(DEPTH) + 1;
    typedef enum logic {IDLE, GRANT} state_t;
    state_t        state, state_n;
    logic [IW-1:0] rr_ptr, rr_n, grant_id, grant_n, sel, idx;
    logic [OW-1:0] occ, occ_n;
    logic          err, err_n, found, rdy, wr, rd, done;
    // First valid requester at or after rr_ptr, wrapping.
    always_comb begin
        sel   = '0;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
        end
    end
    // rst gates the strobes so a burst abandoned by reset writes nothing that cycle.
    assign rdy = !rst && bus.enable && state == GRANT && occ < OW'(DEPTH);
    assign wr  = rdy && bus.req_valid[grant_id];
    assign rd  = bus.fifo_rd_en && bus.enable && occ != '0;
`ifdef ARB_BURST_LOCK_EN
    assign done = wr && bus.req_last[grant_id];
`else
    logic unused_last;
    assign unused_last = ^bus.req_last;
    assign done = wr;
`endif
    assign bus.req_ready     = rdy ? NUM_REQ'(1) << grant_id : '0;
    assign bus.fifo_wr_en    = wr;
    assign bus.fifo_data_in  = bus.req_data[int'(grant_id)*WIDTH +: WIDTH];
    assign bus.grant_id      = grant_id;
    assign bus.busy          = state == GRANT;
    assign bus.occupancy     = occ;
    assign bus.err_underflow = err;
    always_comb begin
        state_n = state;
        grant_n = grant_id;
        rr_n    = rr_ptr;
        if (bus.enable && state == IDLE && |bus.req_valid) begin
            state_n = GRANT;
            grant_n = sel;
        end
        if (state == GRANT && done) begin
            state_n = IDLE;
            rr_n    = grant_id == IW'(NUM_REQ - 1) ? '0 : grant_id + 1'b1;
        end
        occ_n = occ + OW'(wr) - OW'(rd);
        err_n = err || (bus.fifo_rd_en && bus.enable && occ == '0);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            occ      <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            rr_ptr   <= rr_n;
            grant_id <= grant_n;
            occ      <= occ_n;
            err      <= err_n;
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed vector bench for fifo_wr_arbiter (NUM_REQ=4, WIDTH=8, DEPTH=4)
module tb_fifo_wr_arbiter;
    localparam int N = 4, W = 8, D = 4;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    fifo_wr_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D)) bus();
    fifo_wr_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .bus(bus));
    int n_chk = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    task automatic drive(input bit r, input bit e, input logic [3:0] v, input logic [3:0] l, input bit rd);
        rst            = r;
        bus.enable     = e;
        bus.req_valid  = v;
        bus.req_last   = l;
        bus.fifo_rd_en = rd;
    endtask
`ifndef ARB_BURST_LOCK_EN
    typedef struct {
        bit r; bit e; logic [3:0] v; logic [3:0] l; bit rd;
        logic [3:0] rdy; bit wr; logic [1:0] g; bit b; logic [2:0] o; bit er;
    } vec_t;
    vec_t tv[$];
    task automatic add(input bit r, input bit e, input logic [3:0] v, input bit rd,
                       input logic [3:0] rdy, input bit wr, input logic [1:0] g,
                       input bit b, input logic [2:0] o, input bit er);
        vec_t x;
        x.r = r; x.e = e; x.v = v; x.l = 4'b0000; x.rd = rd;
        x.rdy = rdy; x.wr = wr; x.g = g; x.b = b; x.o = o; x.er = er;
        tv.push_back(x);
    endtask
    initial begin
        // rst  en  valid    rd | ready    wr g  busy occ err
        add(0, 1, 4'b0000, 0,   4'b0000, 0, 0, 0, 0, 0);
        add(0, 1, 4'b0011, 0,   4'b0000, 0, 0, 0, 0, 0);
        add(0, 1, 4'b0011, 0,   4'b0001, 1, 0, 1, 0, 0);
        add(0, 1, 4'b0011, 0,   4'b0000, 0, 0, 0, 1, 0);
        add(0, 1, 4'b0011, 0,   4'b0010, 1, 1, 1, 1, 0);
        add(0, 0, 4'b0011, 0,   4'b0000, 0, 1, 0, 2, 0);
        add(0, 0, 4'b0011, 1,   4'b0000, 0, 1, 0, 2, 0);
        add(0, 0, 4'b0011, 0,   4'b0000, 0, 1, 0, 2, 0);
        add(0, 1, 4'b0011, 0,   4'b0000, 0, 1, 0, 2, 0);
        add(0, 1, 4'b0011, 1,   4'b0001, 1, 0, 1, 2, 0);
        add(0, 1, 4'b0011, 1,   4'b0000, 0, 0, 0, 2, 0);
        add(0, 1, 4'b0000, 1,   4'b0010, 0, 1, 1, 1, 0);
        add(0, 1, 4'b0000, 1,   4'b0010, 0, 1, 1, 0, 0);
        add(0, 1, 4'b0000, 0,   4'b0010, 0, 1, 1, 0, 1);
        add(0, 1, 4'b0010, 0,   4'b0010, 1, 1, 1, 0, 1);
        add(0, 1, 4'b0010, 0,   4'b0000, 0, 1, 0, 1, 1);
        add(0, 1, 4'b0010, 0,   4'b0010, 1, 1, 1, 1, 1);
        add(0, 1, 4'b0010, 0,   4'b0000, 0, 1, 0, 2, 1);
        add(0, 1, 4'b0010, 0,   4'b0010, 1, 1, 1, 2, 1);
        add(0, 1, 4'b0010, 0,   4'b0000, 0, 1, 0, 3, 1);
        add(0, 1, 4'b0010, 0,   4'b0010, 1, 1, 1, 3, 1);
        add(0, 1, 4'b0010, 0,   4'b0000, 0, 1, 0, 4, 1);
        add(0, 1, 4'b0010, 0,   4'b0000, 0, 1, 1, 4, 1);
        add(0, 1, 4'b0010, 1,   4'b0000, 0, 1, 1, 4, 1);
        add(0, 1, 4'b0010, 0,   4'b0010, 1, 1, 1, 3, 1);
        add(0, 1, 4'b0010, 1,   4'b0000, 0, 1, 0, 4, 1);
        add(1, 1, 4'b0010, 0,   4'b0000, 0, 1, 1, 3, 1);
        add(0, 1, 4'b0000, 0,   4'b0000, 0, 0, 0, 0, 0);
        bus.req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        drive(1, 1, 4'b0000, 4'b0000, 0);
        @(negedge clk);
        for (int i = 0; i < tv.size(); i++) begin
            drive(tv[i].r, tv[i].e, tv[i].v, tv[i].l, tv[i].rd);
            #1;
            chk($sformatf("v%0d req_ready", i), bus.req_ready, tv[i].rdy);
            chk($sformatf("v%0d fifo_wr_en", i), bus.fifo_wr_en, tv[i].wr);
            chk($sformatf("v%0d grant_id", i), bus.grant_id, tv[i].g);
            chk($sformatf("v%0d fifo_data_in", i), bus.fifo_data_in, {6'b101000, tv[i].g});
            chk($sformatf("v%0d busy", i), bus.busy, tv[i].b);
            chk($sformatf("v%0d occupancy", i), bus.occupancy, tv[i].o);
            chk($sformatf("v%0d err_underflow", i), bus.err_underflow, tv[i].er);
            @(negedge clk);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
`else
    int bc[N];
    int blen;
    int nw;
    logic [1:0] gq[$];
    logic [7:0] dq[$];
    logic [3:0] lastv;
    task automatic prep();
        for (int i = 0; i < N; i++) begin
            bus.req_data[i*W +: W] = {i[3:0], bc[i][3:0]};
            lastv[i] = bc[i] == blen - 1;
        end
    endtask
    task automatic post();
        if (bus.fifo_wr_en) begin
            gq.push_back(bus.grant_id);
            dq.push_back(bus.fifo_data_in);
            nw++;
        end
        for (int i = 0; i < N; i++)
            if (bus.req_ready[i] && bus.req_valid[i]) bc[i] = lastv[i] ? 0 : bc[i] + 1;
    endtask
    task automatic do_reset(input int len);
        blen = len;
        nw = 0;
        gq.delete();
        dq.delete();
        for (int i = 0; i < N; i++) bc[i] = 0;
        prep();
        drive(1, 1, 4'b0000, 4'b0000, 0);
        @(negedge clk);
    endtask
    initial begin
        bus.req_data = '0;
        do_reset(2);
        for (int c = 0; c < 60 && nw < 10; c++) begin
            prep();
            drive(0, 1, 4'b1111, lastv, 1);
            #1;
            post();
            @(negedge clk);
        end
        chk("rr beats written", nw, 10);
        for (int k = 0; k < gq.size(); k++) begin
            int eg;
            eg = (k / 2) % 4;
            chk($sformatf("rr grant %0d", k), gq[k], eg[1:0]);
            chk($sformatf("rr data %0d", k), dq[k], {eg[3:0], 4'(k % 2)});
        end
        do_reset(6);
        for (int c = 0; c < 12; c++) begin
            prep();
            drive(0, 1, 4'b0100, lastv, 0);
            #1;
            post();
            @(negedge clk);
        end
        prep();
        drive(0, 1, 4'b0100, lastv, 0);
        #1;
        chk("full beats written", nw, 4);
        chk("full occupancy", bus.occupancy, 4);
        chk("full req_ready", bus.req_ready, 4'b0000);
        chk("full grant_id", bus.grant_id, 2);
        chk("full busy", bus.busy, 1);
        for (int j = 0; j < 2; j++) begin
            prep();
            drive(0, 1, 4'b0100, lastv, 1);
            #1;
            chk($sformatf("stall%0d fifo_wr_en", j), bus.fifo_wr_en, 0);
            post();
            @(negedge clk);
            prep();
            drive(0, 1, 4'b0100, lastv, 0);
            #1;
            chk($sformatf("resume%0d req_ready", j), bus.req_ready, 4'b0100);
            chk($sformatf("resume%0d fifo_wr_en", j), bus.fifo_wr_en, 1);
            chk($sformatf("resume%0d occupancy", j), bus.occupancy, 3);
            post();
            @(negedge clk);
        end
        drive(0, 1, 4'b0000, 4'b0000, 0);
        #1;
        chk("burst6 beats written", nw, 6);
        chk("burst6 released", bus.busy, 0);
        @(negedge clk);
        do_reset(3);
        for (int c = 0; c < 2; c++) begin
            prep();
            drive(0, 1, 4'b0001, lastv, 0);
            #1;
            post();
            @(negedge clk);
        end
        prep();
        drive(1, 1, 4'b0001, lastv, 0);
        #1;
        chk("rst mid-burst busy before", bus.busy, 1);
        chk("rst mid-burst fifo_wr_en", bus.fifo_wr_en, 0);
        chk("rst mid-burst req_ready", bus.req_ready, 4'b0000);
        @(negedge clk);
        drive(0, 1, 4'b0000, 4'b0000, 0);
        #1;
        chk("after rst busy", bus.busy, 0);
        chk("after rst occupancy", bus.occupancy, 0);
        chk("after rst grant_id", bus.grant_id, 0);
        chk("after rst beats", nw, 1);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
`endif
endmodule
